// File: rtl/ddr_port_arbiter_pkg.sv
// Shared state encoding, default widths and pointer helper for the DDR port arbiter.
package ddr_port_arbiter_pkg;

    localparam int DDR_ADDR_W = 32;
    localparam int DDR_DATA_W = 32;
    localparam int DDR_LEN_W  = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        RD_DATA  = 2'd2,
        WR_ISSUE = 2'd3
    } ddr_arb_state_t;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/ddr_port_arbiter_if.sv
// Core-side request/return bus and DDR-side read/write ports of the arbiter.
interface ddr_port_arbiter_if
    import ddr_port_arbiter_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = DDR_ADDR_W,
    parameter int DATA_W    = DDR_DATA_W,
    parameter int LEN_W     = DDR_LEN_W
);
    logic [NUM_CORES-1:0]        core_rd_req;
    logic [NUM_CORES*ADDR_W-1:0] core_rd_addr;
    logic [NUM_CORES*LEN_W-1:0]  core_rd_len;
    logic [NUM_CORES-1:0]        core_rd_grant;
    logic [DATA_W-1:0]           core_rd_data;
    logic [NUM_CORES-1:0]        core_rd_valid;
    logic [NUM_CORES-1:0]        core_wr_req;
    logic [NUM_CORES*ADDR_W-1:0] core_wr_addr;
    logic [NUM_CORES*DATA_W-1:0] core_wr_data;
    logic [NUM_CORES-1:0]        core_wr_grant;
    logic                        ddr_read_req;
    logic [ADDR_W-1:0]           ddr_read_addr;
    logic [LEN_W-1:0]            ddr_read_len;
    logic                        ddr_read_grant;
    logic [DATA_W-1:0]           ddr_read_data;
    logic                        ddr_read_valid;
    logic                        ddr_write_req;
    logic [ADDR_W-1:0]           ddr_write_addr;
    logic [DATA_W-1:0]           ddr_write_data;
    logic                        ddr_write_grant;

    modport slave (
        input  core_rd_req, core_rd_addr, core_rd_len, core_wr_req, core_wr_addr, core_wr_data,
               ddr_read_grant, ddr_read_data, ddr_read_valid, ddr_write_grant,
        output core_rd_grant, core_rd_data, core_rd_valid, core_wr_grant,
               ddr_read_req, ddr_read_addr, ddr_read_len,
               ddr_write_req, ddr_write_addr, ddr_write_data
    );

    modport master (
        output core_rd_req, core_rd_addr, core_rd_len, core_wr_req, core_wr_addr, core_wr_data,
               ddr_read_grant, ddr_read_data, ddr_read_valid, ddr_write_grant,
        input  core_rd_grant, core_rd_data, core_rd_valid, core_wr_grant,
               ddr_read_req, ddr_read_addr, ddr_read_len,
               ddr_write_req, ddr_write_addr, ddr_write_data
    );

endinterface

// File: rtl/ddr_port_arbiter_rr.sv
// Round-robin picker: first requester at or after the pointer wins; pointer moves past it when enabled.
module rr_arbiter
    import ddr_port_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N-1:0]     req_i,
    input  logic             en_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] cand_s;
    logic             hit_s;

    // Scan requesters in rotated order starting at the pointer.
    always_comb begin
        gnt_o  = '0;
        idx_o  = '0;
        any_o  = 1'b0;
        cand_s = '0;
        hit_s  = 1'b0;
        for (int i = 0; i < N; i++) begin
            cand_s        = IDX_W'((int'(ptr_q) + i) % N);
            hit_s         = req_i[cand_s] && !any_o;
            gnt_o[cand_s] = gnt_o[cand_s] | hit_s;
            idx_o         = hit_s ? cand_s : idx_o;
            any_o         = any_o | hit_s;
        end
    end

    // Pointer advances only when this channel's winner is actually taken.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else if (en_i && any_o) begin
            ptr_q <= IDX_W'(rr_next(int'(idx_o), N));
        end
    end

endmodule

// File: rtl/ddr_port_arbiter.sv
// Shares one DDR read port and one DDR write port among NUM_CORES cores, one transaction at a time.
module ddr_port_arbiter
    import ddr_port_arbiter_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = DDR_ADDR_W,
    parameter int DATA_W    = DDR_DATA_W,
    parameter int LEN_W     = DDR_LEN_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    ddr_port_arbiter_if.slave bus,
    output logic              busy_o
);
    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    ddr_arb_state_t       state_q;
    logic                 busy_q;
    logic                 pref_wr_q;
    logic [IDX_W-1:0]     owner_q;
    logic [LEN_W-1:0]     cnt_q;
    logic                 rd_req_q;
    logic                 wr_req_q;
    logic [ADDR_W-1:0]    rd_addr_q;
    logic [ADDR_W-1:0]    wr_addr_q;
    logic [LEN_W-1:0]     rd_len_q;
    logic [DATA_W-1:0]    wr_data_q;
    logic [DATA_W-1:0]    rd_data_q;
    logic [NUM_CORES-1:0] rd_grant_q;
    logic [NUM_CORES-1:0] wr_grant_q;
    logic [NUM_CORES-1:0] rd_valid_q;

    logic [NUM_CORES-1:0] rd_pend_s, wr_pend_s, rd_gnt_s, wr_gnt_s;
    logic [IDX_W-1:0]     rd_idx_s, wr_idx_s;
    logic                 rd_any_s, wr_any_s, pick_rd_s, pick_wr_s;
    logic [ADDR_W-1:0]    rd_addr_s, wr_addr_s;
    logic [LEN_W-1:0]     rd_len_s;
    logic [DATA_W-1:0]    wr_data_s;
    logic [LEN_W:0]       cnt_nxt_s;

    // A core still holds its request during its grant pulse; that cycle must not re-arbitrate it.
    assign rd_pend_s = bus.core_rd_req & ~rd_grant_q;
    assign wr_pend_s = bus.core_wr_req & ~wr_grant_q;
    assign pick_rd_s = (state_q == IDLE) && rd_any_s && (!wr_any_s || !pref_wr_q);
    assign pick_wr_s = (state_q == IDLE) && wr_any_s && !pick_rd_s;
    assign cnt_nxt_s = {1'b0, cnt_q} + {{LEN_W{1'b0}}, 1'b1};

    rr_arbiter #(.N(NUM_CORES)) u_rd_rr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i (rd_pend_s),
        .en_i  (pick_rd_s),
        .gnt_o (rd_gnt_s),
        .idx_o (rd_idx_s),
        .any_o (rd_any_s)
    );

    rr_arbiter #(.N(NUM_CORES)) u_wr_rr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i (wr_pend_s),
        .en_i  (pick_wr_s),
        .gnt_o (wr_gnt_s),
        .idx_o (wr_idx_s),
        .any_o (wr_any_s)
    );

    // AND-OR select of the winning core's request fields.
    always_comb begin
        rd_addr_s = '0;
        rd_len_s  = '0;
        wr_addr_s = '0;
        wr_data_s = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            rd_addr_s = rd_addr_s | (bus.core_rd_addr[i*ADDR_W +: ADDR_W] & {ADDR_W{rd_gnt_s[i]}});
            rd_len_s  = rd_len_s  | (bus.core_rd_len[i*LEN_W +: LEN_W]    & {LEN_W{rd_gnt_s[i]}});
            wr_addr_s = wr_addr_s | (bus.core_wr_addr[i*ADDR_W +: ADDR_W] & {ADDR_W{wr_gnt_s[i]}});
            wr_data_s = wr_data_s | (bus.core_wr_data[i*DATA_W +: DATA_W] & {DATA_W{wr_gnt_s[i]}});
        end
    end

    // Transaction FSM with latched request fields, beat counter and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            pref_wr_q  <= 1'b0;
            owner_q    <= '0;
            cnt_q      <= '0;
            rd_req_q   <= 1'b0;
            wr_req_q   <= 1'b0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            rd_len_q   <= '0;
            wr_data_q  <= '0;
            rd_data_q  <= '0;
            rd_grant_q <= '0;
            wr_grant_q <= '0;
            rd_valid_q <= '0;
        end else begin
            rd_grant_q <= '0;
            wr_grant_q <= '0;
            rd_valid_q <= '0;
            case (state_q)
                IDLE: begin
                    if (pick_rd_s) begin
                        state_q   <= RD_ISSUE;
                        busy_q    <= 1'b1;
                        owner_q   <= rd_idx_s;
                        rd_req_q  <= 1'b1;
                        rd_addr_q <= rd_addr_s;
                        rd_len_q  <= (rd_len_s == '0) ? LEN_W'(1) : rd_len_s;
                        cnt_q     <= '0;
                    end else if (pick_wr_s) begin
                        state_q   <= WR_ISSUE;
                        busy_q    <= 1'b1;
                        owner_q   <= wr_idx_s;
                        wr_req_q  <= 1'b1;
                        wr_addr_q <= wr_addr_s;
                        wr_data_q <= wr_data_s;
                    end
                    if (rd_any_s && wr_any_s) begin
                        pref_wr_q <= !pref_wr_q;
                    end
                end
                RD_ISSUE: begin
                    if (bus.ddr_read_grant) begin
                        state_q             <= RD_DATA;
                        rd_req_q            <= 1'b0;
                        rd_grant_q[owner_q] <= 1'b1;
                    end
                end
                RD_DATA: begin
                    if (bus.ddr_read_valid) begin
                        rd_data_q           <= bus.ddr_read_data;
                        rd_valid_q[owner_q] <= 1'b1;
                        cnt_q               <= cnt_nxt_s[LEN_W-1:0];
                        if (cnt_nxt_s >= {1'b0, rd_len_q}) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                WR_ISSUE: begin
                    if (bus.ddr_write_grant) begin
                        state_q             <= IDLE;
                        busy_q              <= 1'b0;
                        wr_req_q            <= 1'b0;
                        wr_grant_q[owner_q] <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.core_rd_grant  = rd_grant_q;
    assign bus.core_wr_grant  = wr_grant_q;
    assign bus.core_rd_valid  = rd_valid_q;
    assign bus.core_rd_data   = rd_data_q;
    assign bus.ddr_read_req   = rd_req_q;
    assign bus.ddr_read_addr  = rd_addr_q;
    assign bus.ddr_read_len   = rd_len_q;
    assign bus.ddr_write_req  = wr_req_q;
    assign bus.ddr_write_addr = wr_addr_q;
    assign bus.ddr_write_data = wr_data_q;
    assign busy_o             = busy_q;

endmodule
